mod_counter: RTL and testbench

Parametrised up/down modulus counter, successor to the plain loadable counter used for the VeriRISC program counter. Adds configurable width, modulus, step size, count direction, wrap/saturate boundary mode, a terminal-count decode and an overflow pulse. It serves as the program counter, as loop/timeout counters in the controller, and as the address generator for memory test sequencing.

---
 rtl/mod_counter.sv | 94 +++++++++
 tb/tb_mod_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Up/down modulus counter with wrap/saturate boundary, terminal-count decode and overflow pulse.
// Optional sticky overflow flag enabled by MOD_COUNTER_OVF_STICKY_EN.
module mod_counter #(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             ovf,
    output logic             ovf_sticky
);

    localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   C_STEP  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   C_MOD   = C_MAX + 1'b1;
    localparam logic [WIDTH-1:0] C_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_tmp;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    assign w_ext = {1'b0, r_cnt};
    assign w_sum = w_ext + C_STEP;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = 1'b0;
        w_tmp     = '0;
        if (load) begin
            w_cnt_nxt = ({1'b0, cnt_in} > C_MAX) ? C_MAX_W : cnt_in;
        end else if (enab) begin
            if (dir) begin
                if (w_sum <= C_MAX) begin
                    w_cnt_nxt = w_sum[WIDTH-1:0];
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_tmp     = w_sum - C_MOD;
                    w_cnt_nxt = sat ? C_MAX_W : w_tmp[WIDTH-1:0];
                end
            end else begin
                if (w_ext >= C_STEP) begin
                    w_tmp     = w_ext - C_STEP;
                    w_cnt_nxt = w_tmp[WIDTH-1:0];
                end else begin
                    // Borrow: result stays below the modulus, so WIDTH+1 bits suffice.
                    w_ovf_nxt = 1'b1;
                    w_tmp     = w_ext + (C_MOD - C_STEP);
                    w_cnt_nxt = sat ? '0 : w_tmp[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic r_sticky;
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_sticky <= 1'b0;
        end else if (w_ovf_nxt) begin
            r_sticky <= 1'b1;
        end
    end
    assign ovf_sticky = r_sticky;
`else
    assign ovf_sticky = 1'b0;
`endif

    assign cnt_out = r_cnt;
    assign ovf     = r_ovf;
    assign tc      = dir ? (r_cnt == C_MAX_W) : (r_cnt == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three parameterisations share one stimulus stream, each checked against its own model.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1, load = 1'b0, enab = 1'b0, dir = 1'b0, sat = 1'b0;
    logic [4:0] cnt_in = '0;
    logic [4:0] cnt_o [3];
    logic       tc_o  [3];
    logic       ovf_o [3];
    logic       st_o  [3];

    int checks = 0;
    int failures = 0;

    // d0: defaults (31, step 1); d1: max 23 step 1; d2: max 23 step 3
    int maxv  [3] = '{31, 23, 23};
    int stepv [3] = '{1, 1, 3};
    int m_cnt [3] = '{0, 0, 0};
    int m_ovf [3] = '{0, 0, 0};
    int m_st  [3] = '{0, 0, 0};

`ifdef MOD_COUNTER_OVF_STICKY_EN
    localparam int STICKY_ON = 1;
`else
    localparam int STICKY_ON = 0;
`endif

    always #5 clk = ~clk;

    mod_counter u_d0 (.clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir), .sat(sat),
        .cnt_in(cnt_in), .cnt_out(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .ovf_sticky(st_o[0]));
    mod_counter #(.WIDTH(5), .MAX_VAL(23), .STEP(1)) u_d1 (.clk(clk), .rst(rst), .load(load),
        .enab(enab), .dir(dir), .sat(sat), .cnt_in(cnt_in), .cnt_out(cnt_o[1]), .tc(tc_o[1]),
        .ovf(ovf_o[1]), .ovf_sticky(st_o[1]));
    mod_counter #(.WIDTH(5), .MAX_VAL(23), .STEP(3)) u_d2 (.clk(clk), .rst(rst), .load(load),
        .enab(enab), .dir(dir), .sat(sat), .cnt_in(cnt_in), .cnt_out(cnt_o[2]), .tc(tc_o[2]),
        .ovf(ovf_o[2]), .ovf_sticky(st_o[2]));

    // Reference behaviour: modular arithmetic over 0..max, clamped when saturating.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int m, c;
            m = maxv[k] + 1;
            c = m_cnt[k];
            if (rst) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_st[k] = 0;
            end else if (load) begin
                m_cnt[k] = (int'(cnt_in) > maxv[k]) ? maxv[k] : int'(cnt_in);
                m_ovf[k] = 0; m_st[k] = 0;
            end else if (enab) begin
                if (dir) begin
                    m_ovf[k] = (c + stepv[k] >= m) ? 1 : 0;
                    m_cnt[k] = (m_ovf[k] == 1 && sat) ? maxv[k] : (c + stepv[k]) % m;
                end else begin
                    m_ovf[k] = (c - stepv[k] < 0) ? 1 : 0;
                    m_cnt[k] = (m_ovf[k] == 1 && sat) ? 0 : ((c - stepv[k]) % m + m) % m;
                end
                if (m_ovf[k] == 1 && STICKY_ON == 1) m_st[k] = 1;
            end else begin
                m_ovf[k] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; cnt_in = 5'h0A; enab = 1'b1; dir = 1'b0;
        tick();
        rst = 1'b0; load = 1'b0; enab = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_o[k] !== 5'd0 || ovf_o[k] !== 1'b0 || st_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d] cnt=%0d ovf=%b st=%b want 0/0/0", k, cnt_o[k], ovf_o[k], st_o[k]);
            end
        end
        #1;
        checks++;
        if (tc_o[0] !== 1'b1) begin failures++; $display("FAIL reset_tc_down tc=%b want 1", tc_o[0]); end
        dir = 1'b1; #1;
        checks++;
        if (tc_o[0] !== 1'b0) begin failures++; $display("FAIL reset_tc_up tc=%b want 0", tc_o[0]); end
    endtask

    task automatic test_load_rst();
        load = 1'b1; cnt_in = 5'h15;
        tick();
        checks++;
        if (cnt_o[0] !== 5'h15) begin failures++; $display("FAIL load15 cnt=%h want 15", cnt_o[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        checks++;
        if (cnt_o[0] !== 5'h00 || ovf_o[0] !== 1'b0) begin
            failures++; $display("FAIL rst_over_load cnt=%h ovf=%b want 00/0", cnt_o[0], ovf_o[0]);
        end
    endtask

    task automatic test_wrap_step1();
        load = 1'b1; cnt_in = 5'd22; dir = 1'b1; sat = 1'b0;
        tick();
        load = 1'b0; enab = 1'b1;
        tick();
        checks++;
        if (cnt_o[1] !== 5'd23 || tc_o[1] !== 1'b1 || ovf_o[1] !== 1'b0) begin
            failures++; $display("FAIL wrap1_a cnt=%0d tc=%b ovf=%b want 23/1/0", cnt_o[1], tc_o[1], ovf_o[1]);
        end
        tick();
        enab = 1'b0;
        checks++;
        if (cnt_o[1] !== 5'd0 || ovf_o[1] !== 1'b1) begin
            failures++; $display("FAIL wrap1_b cnt=%0d ovf=%b want 0/1", cnt_o[1], ovf_o[1]);
        end
        tick();
        checks++;
        if (cnt_o[1] !== 5'd0 || ovf_o[1] !== 1'b0) begin
            failures++; $display("FAIL wrap1_pulse cnt=%0d ovf=%b want 0/0", cnt_o[1], ovf_o[1]);
        end
    endtask

    task automatic test_step3();
        load = 1'b1; cnt_in = 5'd22; dir = 1'b1; sat = 1'b0;
        tick();
        load = 1'b0; enab = 1'b1;
        tick();
        checks++;
        if (cnt_o[2] !== 5'd1 || ovf_o[2] !== 1'b1) begin
            failures++; $display("FAIL step3_up cnt=%0d ovf=%b want 1/1", cnt_o[2], ovf_o[2]);
        end
        dir = 1'b0;
        tick();
        enab = 1'b0;
        checks++;
        if (cnt_o[2] !== 5'd22 || ovf_o[2] !== 1'b1) begin
            failures++; $display("FAIL step3_down cnt=%0d ovf=%b want 22/1", cnt_o[2], ovf_o[2]);
        end
    endtask

    task automatic test_saturate();
        logic [4:0] exp_c [3] = '{5'd23, 5'd23, 5'd23};
        logic       exp_o [3] = '{1'b0, 1'b1, 1'b1};
        load = 1'b1; cnt_in = 5'd22; dir = 1'b1; sat = 1'b1;
        tick();
        load = 1'b0; enab = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cnt_o[1] !== exp_c[i] || ovf_o[1] !== exp_o[i]) begin
                failures++;
                $display("FAIL sat_up[%0d] cnt=%0d ovf=%b want %0d/%b", i, cnt_o[1], ovf_o[1], exp_c[i], exp_o[i]);
            end
        end
        load = 1'b1; cnt_in = 5'd0;
        tick();
        load = 1'b0; dir = 1'b0;
        tick();
        enab = 1'b0;
        checks++;
        if (cnt_o[1] !== 5'd0 || ovf_o[1] !== 1'b1) begin
            failures++; $display("FAIL sat_down cnt=%0d ovf=%b want 0/1", cnt_o[1], ovf_o[1]);
        end
        sat = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; cnt_in = 5'h1F;
        tick();
        checks++;
        if (cnt_o[1] !== 5'd23 || cnt_o[0] !== 5'd31) begin
            failures++; $display("FAIL clamp d1=%0d d0=%0d want 23/31", cnt_o[1], cnt_o[0]);
        end
        cnt_in = 5'd5; enab = 1'b1; dir = 1'b1;
        tick();
        load = 1'b0; enab = 1'b0;
        checks++;
        if (cnt_o[1] !== 5'd5 || ovf_o[1] !== 1'b0) begin
            failures++; $display("FAIL load_wins cnt=%0d ovf=%b want 5/0", cnt_o[1], ovf_o[1]);
        end
    endtask

    task automatic test_sticky();
        load = 1'b1; cnt_in = 5'd23; dir = 1'b1; sat = 1'b0;
        tick();
        load = 1'b0; enab = 1'b1;
        tick();
        enab = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st_o[1] !== 1'(STICKY_ON)) begin
                failures++; $display("FAIL sticky_hold[%0d] st=%b want %0d", i, st_o[1], STICKY_ON);
            end
            tick();
        end
        load = 1'b1; cnt_in = 5'd3;
        tick();
        load = 1'b0;
        checks++;
        if (st_o[1] !== 1'b0) begin failures++; $display("FAIL sticky_clear st=%b want 0", st_o[1]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 39) == 0);
            load   = ($urandom_range(0, 9) == 0);
            enab   = ($urandom_range(0, 3) != 0);
            dir    = 1'($urandom);
            sat    = ($urandom_range(0, 2) == 0);
            cnt_in = 5'($urandom);
            tick();
            dir = 1'($urandom); #1;
            for (int k = 0; k < 3; k++) begin
                int exp_tc;
                exp_tc = dir ? int'(m_cnt[k] == maxv[k]) : int'(m_cnt[k] == 0);
                checks++;
                if (int'(cnt_o[k]) != m_cnt[k] || int'(ovf_o[k]) != m_ovf[k] ||
                    int'(st_o[k]) != m_st[k] || int'(tc_o[k]) != exp_tc) begin
                    failures++;
                    $display("FAIL rand[%0d] dut%0d cnt=%0d ovf=%b st=%b tc=%b want %0d/%0d/%0d/%0d",
                             n, k, cnt_o[k], ovf_o[k], st_o[k], tc_o[k], m_cnt[k], m_ovf[k], m_st[k], exp_tc);
                end
            end
        end
        rst = 1'b0; load = 1'b0; enab = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_rst();
        test_wrap_step1();
        test_step3();
        test_saturate();
        test_load_clamp();
        test_sticky();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
